// File: rtl/ram_bank_scheduler_if.sv
// Bundle of stream, replay and RAM-port signals for ram_bank_scheduler.
// master = scheduler side, slave = stream source/sink plus RAM.
interface ram_bank_scheduler_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        rd_req;
    logic        rd_busy;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] bank_full;
    logic        wr_en;
    logic [9:0]  address_wr;
    logic [7:0]  data;
    logic [3:0]  ram_select_wr;
    logic        rd_en;
    logic [9:0]  address_rd;
    logic [3:0]  ram_select_rd;
    logic [7:0]  q;

    modport master (
        input  in_valid, in_data, rd_req, q,
        output in_ready, rd_busy, out_valid, out_data, out_last, bank_full,
               wr_en, address_wr, data, ram_select_wr,
               rd_en, address_rd, ram_select_rd
    );

    modport slave (
        output in_valid, in_data, rd_req, q,
        input  in_ready, rd_busy, out_valid, out_data, out_last, bank_full,
               wr_en, address_wr, data, ram_select_wr,
               rd_en, address_rd, ram_select_rd
    );
endinterface

// File: rtl/ram_bank_scheduler.sv
// Bank-granular FIFO over a 16-bank 2-port RAM: frames fill banks round-robin, replay frees them.
// Optional stall counter output ovf_cnt when RAM_SCHED_OVF_CNT_EN is defined.
module ram_bank_scheduler #(
    parameter int NUM_BANKS  = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    ram_bank_scheduler_if.master bus
`ifdef RAM_SCHED_OVF_CNT_EN
    ,
    output logic [15:0] ovf_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam logic [3:0] LAST_BANK  = 4'(NUM_BANKS - 1);
    localparam logic [9:0] LAST_ADDR  = 10'(FRAME_LEN - 1);
    localparam logic [1:0] LAST_DRAIN = 2'(RD_LATENCY - 1);

    function automatic logic [3:0] next_bank(input logic [3:0] b);
        return (b == LAST_BANK) ? 4'd0 : b + 4'd1;
    endfunction

    logic [3:0]  wr_bank;
    logic [9:0]  wr_addr;
    logic        wr_en_q;
    logic [9:0]  address_wr_q;
    logic [7:0]  data_q;
    logic [3:0]  sel_wr_q;
    logic [15:0] bank_full_q;
    logic [15:0] set_mask;
    logic [15:0] clr_mask;
    logic        in_ready;
    logic        accept;
    logic        frame_done;

    rd_state_t   state;
    rd_state_t   state_n;
    logic [3:0]  rd_bank;
    logic [9:0]  rd_addr;
    logic [1:0]  drain_cnt;
    logic        rd_en;
    logic        rd_last;

    logic [RD_LATENCY-1:0] vld_p;
    logic [RD_LATENCY-1:0] last_p;

    assign in_ready   = !rst && !bank_full_q[wr_bank];
    assign accept     = bus.in_valid && in_ready;
    assign frame_done = accept && (wr_addr == LAST_ADDR);

    always_comb begin
        set_mask = '0;
        if (frame_done)
            set_mask[wr_bank] = 1'b1;
    end

    // Write stage: accepted byte is presented to the RAM one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank      <= '0;
            wr_addr      <= '0;
            wr_en_q      <= 1'b0;
            address_wr_q <= '0;
            data_q       <= '0;
            sel_wr_q     <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                data_q       <= bus.in_data;
                address_wr_q <= wr_addr;
                sel_wr_q     <= wr_bank;
                wr_addr      <= frame_done ? 10'd0 : wr_addr + 10'd1;
                if (frame_done)
                    wr_bank <= next_bank(wr_bank);
            end
        end
    end

    // Set and clear never target the same bank, so both can apply in one cycle
    always_ff @(posedge clk) begin
        if (rst)
            bank_full_q <= '0;
        else
            bank_full_q <= (bank_full_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        clr_mask = '0;
        case (state)
            IDLE: begin
                if (bus.rd_req && bank_full_q[rd_bank])
                    state_n = READ;
            end
            READ: begin
                if (rd_addr == LAST_ADDR)
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == LAST_DRAIN) begin
                    state_n           = IDLE;
                    clr_mask[rd_bank] = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank   <= '0;
            rd_addr   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_addr   <= '0;
                    drain_cnt <= '0;
                end
                READ: begin
                    rd_addr <= (rd_addr == LAST_ADDR) ? 10'd0 : rd_addr + 10'd1;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == LAST_DRAIN)
                        rd_bank <= next_bank(rd_bank);
                end
                default: begin
                    rd_addr   <= '0;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    assign rd_en   = (state == READ);
    assign rd_last = rd_en && (rd_addr == LAST_ADDR);

    // Read-data alignment: valid/last track the RAM's fixed read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= rd_en;
            last_p[0] <= rd_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end
    end

`ifdef RAM_SCHED_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            ovf_cnt_q <= '0;
        else if (bus.in_valid && !in_ready && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign bus.in_ready      = in_ready;
    assign bus.rd_busy       = (state != IDLE);
    assign bus.out_valid     = vld_p[RD_LATENCY-1];
    assign bus.out_last      = last_p[RD_LATENCY-1];
    assign bus.out_data      = vld_p[RD_LATENCY-1] ? bus.q : 8'h00;
    assign bus.bank_full     = bank_full_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.address_wr    = address_wr_q;
    assign bus.data          = data_q;
    assign bus.ram_select_wr = sel_wr_q;
    assign bus.rd_en         = rd_en;
    assign bus.address_rd    = rd_addr;
    assign bus.ram_select_rd = rd_bank;

endmodule

// File: tb/tb_ram_bank_scheduler.sv
// Scoreboard bench for ram_bank_scheduler with a behavioural 16-bank RAM.
// Define RAM_SCHED_OVF_CNT_EN for both files to also cover the stall counter.
module tb_ram_bank_scheduler;
    localparam int NB = 16;
    localparam int FL = 1024;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_bank_scheduler_if bus ();
`ifdef RAM_SCHED_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    ram_bank_scheduler #(.NUM_BANKS(NB), .FRAME_LEN(FL), .RD_LATENCY(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RAM_SCHED_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    logic [7:0] mem [NB][FL];
    logic [7:0] q_pipe [RL];

    always @(posedge clk) begin
        if (bus.wr_en)
            mem[bus.ram_select_wr][bus.address_wr] <= bus.data;
        q_pipe[0] <= mem[bus.ram_select_rd][bus.address_rd];
        for (int i = 1; i < RL; i++)
            q_pipe[i] <= q_pipe[i-1];
    end
    assign bus.q = q_pipe[RL-1];

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   wr_count = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.rd_req   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        wr_count = 0;
    endtask

    task automatic write_bytes(input int n, input int seed);
        logic [7:0] d;
        int g;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = 8'((i + (i / FL) * 37 + seed) & 255);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            g = 0;
            while (!bus.in_ready && g < 4000) begin
                @(negedge clk);
                g++;
            end
            if (g >= 4000) begin
                checks++;
                failures++;
                $display("FAIL write_timeout in_ready=%0b want 1", bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            sb.push_back('{d: d, l: ((wr_count % FL) == FL - 1)});
            wr_count++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic read_frames(input int nframes, input bit hold, output int first_rd,
                               output int lat, output int gap_min, output int gap_max,
                               output int collisions);
        int frames, cyc, idle_run, g;
        bit seen_busy;
        exp_t e;
        frames = 0; cyc = 0; first_rd = -1; lat = -1;
        gap_min = 1000; gap_max = -1; collisions = 0; idle_run = 0; seen_busy = 0;
        @(negedge clk);
        bus.rd_req = 1'b1;
        while (frames < nframes && cyc < nframes * (FL + 10) + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.rd_busy && !hold)
                bus.rd_req = 1'b0;
            if (bus.rd_en && first_rd < 0)
                first_rd = cyc;
            if (bus.rd_en && bus.wr_en && bus.ram_select_rd == bus.ram_select_wr &&
                bus.address_rd == bus.address_wr)
                collisions++;
            if (bus.rd_busy) begin
                if (seen_busy && idle_run > 0) begin
                    if (idle_run < gap_min) gap_min = idle_run;
                    if (idle_run > gap_max) gap_max = idle_run;
                end
                idle_run  = 0;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                idle_run++;
            end
            if (bus.out_valid) begin
                if (lat < 0)
                    lat = cyc - first_rd;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL replay_extra data=%02h with empty scoreboard", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_data, bus.out_last} !== {e.d, e.l}) begin
                        failures++;
                        $display("FAIL replay_byte frame=%0d got data=%02h last=%0b want data=%02h last=%0b",
                                 frames, bus.out_data, bus.out_last, e.d, e.l);
                    end
                end
                if (bus.out_last)
                    frames++;
            end
        end
        checks++;
        if (frames != nframes) begin
            failures++;
            $display("FAIL replay_frames got %0d want %0d", frames, nframes);
        end
        g = 0;
        while (bus.rd_busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!hold)
            bus.rd_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [82:0] outs;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.rd_req   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            outs = {bus.wr_en, bus.rd_en, bus.address_wr, bus.address_rd, bus.ram_select_wr,
                    bus.ram_select_rd, bus.data, bus.out_valid, bus.out_data, bus.out_last,
                    bus.bank_full, bus.rd_busy, bus.in_ready};
            checks++;
            if (outs !== '0) begin
                failures++;
                $display("FAIL reset_outputs got %h want 0", outs);
            end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.rd_req   = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.wr_en, bus.rd_busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release in_ready/wr_en/rd_busy=%b want 100",
                     {bus.in_ready, bus.wr_en, bus.rd_busy});
        end
    endtask

    task automatic test_single_frame();
        int first_rd, lat, gmin, gmax, coll;
        write_bytes(FL, 0);
        checks++;
        if ({bus.wr_en, bus.address_wr, bus.data, bus.ram_select_wr} !== {1'b1, 10'd1023, 8'hFF, 4'd0}) begin
            failures++;
            $display("FAIL last_write got en=%0b addr=%0d data=%02h sel=%0d want 1 1023 ff 0",
                     bus.wr_en, bus.address_wr, bus.data, bus.ram_select_wr);
        end
        checks++;
        if (bus.bank_full !== 16'h0001) begin
            failures++;
            $display("FAIL full_after_frame got %h want 0001", bus.bank_full);
        end
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL wr_en_idle got %0b want 0", bus.wr_en);
        end
        read_frames(1, 1'b0, first_rd, lat, gmin, gmax, coll);
        checks++;
        if (first_rd !== 1 || lat !== RL) begin
            failures++;
            $display("FAIL read_timing first_rd=%0d lat=%0d want 1 %0d", first_rd, lat, RL);
        end
        checks++;
        if (coll !== 0) begin
            failures++;
            $display("FAIL rw_collision got %0d want 0", coll);
        end
        checks++;
        if ({bus.bank_full, bus.rd_busy} !== 17'h0) begin
            failures++;
            $display("FAIL free_after_replay bank_full=%h rd_busy=%0b want 0 0", bus.bank_full, bus.rd_busy);
        end
    endtask

`ifdef RAM_SCHED_OVF_CNT_EN
    task automatic test_ovf_cnt();
        checks++;
        if (ovf_cnt !== 16'd10) begin
            failures++;
            $display("FAIL ovf_count got %0d want 10", ovf_cnt);
        end
        bus.in_valid = 1'b1;
        force dut.ovf_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.ovf_cnt_q;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (ovf_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL ovf_saturate got %h want ffff", ovf_cnt);
        end
    endtask
`endif

    task automatic test_fill_all();
        int first_rd, lat, gmin, gmax, coll, wr_seen;
        do_reset();
        write_bytes(NB * FL, 3);
        checks++;
        if ({bus.in_ready, bus.bank_full} !== {1'b0, 16'hFFFF}) begin
            failures++;
            $display("FAIL all_full in_ready=%0b bank_full=%h want 0 ffff", bus.in_ready, bus.bank_full);
        end
        wr_seen = 0;
        bus.in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.wr_en || bus.in_ready) wr_seen++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (wr_seen !== 0) begin
            failures++;
            $display("FAIL stall_when_full got %0d write cycles want 0", wr_seen);
        end
`ifdef RAM_SCHED_OVF_CNT_EN
        test_ovf_cnt();
`endif
        read_frames(1, 1'b0, first_rd, lat, gmin, gmax, coll);
        checks++;
        if ({bus.bank_full, bus.in_ready} !== {16'hFFFE, 1'b1}) begin
            failures++;
            $display("FAIL bank0_freed bank_full=%h in_ready=%0b want fffe 1", bus.bank_full, bus.in_ready);
        end
        write_bytes(1, 99);
        checks++;
        if ({bus.wr_en, bus.ram_select_wr, bus.address_wr, bus.data} !== {1'b1, 4'd0, 10'd0, 8'd99}) begin
            failures++;
            $display("FAIL wrap_write got en=%0b sel=%0d addr=%0d data=%0d want 1 0 0 99",
                     bus.wr_en, bus.ram_select_wr, bus.address_wr, bus.data);
        end
    endtask

    task automatic test_back_to_back();
        int first_rd, lat, gmin, gmax, coll, busy_cnt;
        do_reset();
        write_bytes(3 * FL, 11);
        checks++;
        if (bus.bank_full !== 16'h0007) begin
            failures++;
            $display("FAIL three_full got %h want 0007", bus.bank_full);
        end
        read_frames(3, 1'b1, first_rd, lat, gmin, gmax, coll);
        checks++;
        if (gmin !== 1 || gmax !== 1) begin
            failures++;
            $display("FAIL frame_gap min=%0d max=%0d want 1 1", gmin, gmax);
        end
        busy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rd_busy || bus.rd_en) busy_cnt++;
        end
        bus.rd_req = 1'b0;
        checks++;
        if (busy_cnt !== 0 || bus.bank_full !== 16'h0000) begin
            failures++;
            $display("FAIL empty_req busy_cycles=%0d bank_full=%h want 0 0000", busy_cnt, bus.bank_full);
        end
    endtask

    task automatic test_reset_mid_replay();
        int cnt, g, stale;
        exp_t e;
        do_reset();
        write_bytes(FL, 5);
        @(negedge clk);
        bus.rd_req = 1'b1;
        cnt = 0;
        g = 0;
        while (cnt < 500 && g < 2000) begin
            @(negedge clk);
            g++;
            if (bus.rd_busy) bus.rd_req = 1'b0;
            if (bus.out_valid && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.out_data !== e.d) begin
                    failures++;
                    $display("FAIL partial_byte %0d got %02h want %02h", cnt, bus.out_data, e.d);
                end
                cnt++;
            end
        end
        rst = 1'b1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.bank_full, bus.rd_busy, bus.ram_select_rd, bus.address_rd} !== '0) begin
            failures++;
            $display("FAIL mid_reset out_valid=%0b bank_full=%h busy=%0b sel_rd=%0d addr_rd=%0d want all 0",
                     bus.out_valid, bus.bank_full, bus.rd_busy, bus.ram_select_rd, bus.address_rd);
        end
        rst = 1'b0;
        sb.delete();
        wr_count = 0;
        stale = 0;
        repeat (RL + 2) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checks++;
        if (stale !== 0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stale_valid got %0d cycles in_ready=%0b want 0 1", stale, bus.in_ready);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.rd_req   = 1'b0;
        test_reset();
        test_single_frame();
        test_fill_all();
        test_back_to_back();
        test_reset_mid_replay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
